// File: rtl/alu_issue_pkg.sv
// Shared types for the execute-stage issue/writeback controller.
//   instructions   : decoded instruction record handed over by decode
//   issue_state_t  : controller FSM states
//   writes_rd()    : true when the instruction retires a value to rd
package alu_issue_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_ADDI   = 5'd1,
    OP_SUB    = 5'd2,
    OP_LW     = 5'd3,
    OP_SW     = 5'd4,
    OP_BEQ    = 5'd5,
    OP_BNE    = 5'd6,
    OP_BLT    = 5'd7,
    OP_CSRRW  = 5'd8,
    OP_CSRRS  = 5'd9,
    OP_CSRRC  = 5'd10,
    OP_CSRRWI = 5'd11,
    OP_CSRRSI = 5'd12,
    OP_CSRRCI = 5'd13,
    OP_MUL    = 5'd14,
    OP_DIV    = 5'd15
  } op_t;

  typedef struct packed {
    op_t         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } instructions;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WB    = 2'd2
  } issue_state_t;

  function automatic logic is_branch(input instructions ins);
    case (ins.op)
      OP_BEQ, OP_BNE, OP_BLT: is_branch = 1'b1;
      default:                is_branch = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input instructions ins);
    case (ins.op)
      OP_SW:   is_store = 1'b1;
      default: is_store = 1'b0;
    endcase
  endfunction

  function automatic logic is_csr(input instructions ins);
    case (ins.op)
      OP_CSRRW, OP_CSRRS, OP_CSRRC,
      OP_CSRRWI, OP_CSRRSI, OP_CSRRCI: is_csr = 1'b1;
      default:                         is_csr = 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input instructions ins);
    writes_rd = !(is_branch(ins) || is_store(ins));
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// Architectural integer register file: 32 x 32, x0 hardwired to zero.
//   i_raddr1/o_rdata1, i_raddr2/o_rdata2 : combinational read ports
//   i_we/i_waddr/i_wdata                 : synchronous write port
//   rstn                                 : async active-low, clears all entries
module alu_issue_regfile (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  i_raddr1,
  output logic [31:0] o_rdata1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata2,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata
);

  logic [31:0] r_mem [32];

  // Storage array; writes to x0 are dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : r_mem[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : r_mem[i_raddr2];

endmodule

// File: rtl/alu_issue.sv
// Execute-stage issue/writeback controller in front of the ALU.
// Accepts one decoded instruction in IDLE, reads rs1/rs2 from the internal
// register file, holds operands to the ALU during ISSUE until alu_completed,
// then retires the result for one WB cycle (regfile write, wb/csr/branch pulse).
//   decode side : in_valid, in_ready, in_instr, csr_rdata
//   ALU side    : alu_enabled, alu_instr, alu_rs1/rs2/csr, alu_completed, alu_rd
//   retire side : wb_valid, wb_rd, wb_data, branch_taken, csr_we, csr_wdata
//   status      : timeout_err (sticky until reset)
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  instructions in_instr,
  input  logic [31:0] csr_rdata,
  output logic        alu_enabled,
  output instructions alu_instr,
  output logic [31:0] alu_rs1,
  output logic [31:0] alu_rs2,
  output logic [31:0] alu_csr,
  input  logic        alu_completed,
  input  logic [31:0] alu_rd,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        branch_taken,
  output logic        csr_we,
  output logic [31:0] csr_wdata,
  output logic        timeout_err
);

  localparam int             CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  issue_state_t r_state, w_next;
  logic         w_accept, w_done, w_abort;

  instructions  r_alu_instr;
  logic [31:0]  r_alu_rs1, r_alu_rs2, r_alu_csr;
  logic [CW-1:0] r_cnt;
  logic [4:0]   r_wb_rd;
  logic [31:0]  r_wb_data, r_csr_wdata;
  logic         r_csr_we, r_branch_taken, r_timeout_err;

  logic [31:0]  w_rdata1, w_rdata2;
  logic         w_rf_we;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; completion takes priority over the timeout abort.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_done   = 1'b0;
    w_abort  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_next   = S_ISSUE;
          w_accept = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (alu_completed) begin
          w_next = S_WB;
          w_done = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_next  = S_IDLE;
          w_abort = 1'b1;
        end else begin
          w_next = S_ISSUE;
        end
      end
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand/result datapath. csr_we and branch_taken are set only on the
  // completing ISSUE cycle, so they are high exactly during WB.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_alu_instr    <= '0;
      r_alu_rs1      <= 32'd0;
      r_alu_rs2      <= 32'd0;
      r_alu_csr      <= 32'd0;
      r_cnt          <= '0;
      r_wb_rd        <= 5'd0;
      r_wb_data      <= 32'd0;
      r_csr_wdata    <= 32'd0;
      r_csr_we       <= 1'b0;
      r_branch_taken <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_instr <= in_instr;
        r_alu_rs1   <= w_rdata1;
        r_alu_rs2   <= w_rdata2;
        r_alu_csr   <= csr_rdata;
        r_cnt       <= '0;
      end else if ((r_state == S_ISSUE) && !alu_completed) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
      if (w_done) begin
        r_wb_rd     <= r_alu_instr.rd;
        // CSR ops return the old CSR value to rd; the ALU result goes to the CSR.
        r_wb_data   <= is_csr(r_alu_instr) ? r_alu_csr : alu_rd;
        r_csr_wdata <= alu_rd;
      end
      r_csr_we       <= w_done && is_csr(r_alu_instr);
      r_branch_taken <= w_done && is_branch(r_alu_instr) && alu_rd[0];
      if (w_abort) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign w_rf_we = (r_state == S_WB) && writes_rd(r_alu_instr) && (r_alu_instr.rd != 5'd0);

  alu_issue_regfile u_regfile (
    .clk      (clk),
    .rstn     (rstn),
    .i_raddr1 (in_instr.rs1),
    .o_rdata1 (w_rdata1),
    .i_raddr2 (in_instr.rs2),
    .o_rdata2 (w_rdata2),
    .i_we     (w_rf_we),
    .i_waddr  (r_alu_instr.rd),
    .i_wdata  (r_wb_data)
  );

  assign in_ready     = (r_state == S_IDLE);
  assign alu_enabled  = (r_state == S_ISSUE);
  assign wb_valid     = (r_state == S_WB);
  assign alu_instr    = r_alu_instr;
  assign alu_rs1      = r_alu_rs1;
  assign alu_rs2      = r_alu_rs2;
  assign alu_csr      = r_alu_csr;
  assign wb_rd        = r_wb_rd;
  assign wb_data      = r_wb_data;
  assign csr_wdata    = r_csr_wdata;
  assign csr_we       = r_csr_we;
  assign branch_taken = r_branch_taken;
  assign timeout_err  = r_timeout_err;

endmodule
